// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: WIDTH-bit payload with valid/ready handshake,
// optional 2-entry skid buffer and a saturating count of flushed entries.
module pipe_stage_reg #(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
   parameter logic [WIDTH-1:0] FLUSH_VAL = {WIDTH{1'b0}},
   parameter bit               SKID      = 1'b1,
   parameter int               CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] flush_cnt
);

   logic             main_valid_q, main_valid_d;
   logic [WIDTH-1:0] main_data_q,  main_data_d;
   logic             skid_valid_q, skid_valid_d;
   logic [WIDTH-1:0] skid_data_q,  skid_data_d;
   logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;

   logic             accept;
   logic             emit;
   logic [1:0]       lost_cnt;
   logic [CNT_W:0]   cnt_sum;

   generate
      if (SKID) begin : g_skid_ready
         assign in_ready = !skid_valid_q;
      end else begin : g_comb_ready
         assign in_ready = !main_valid_q | out_ready;
      end
   endgenerate

   assign accept = in_valid & in_ready;
   assign emit   = main_valid_q & out_ready;

   // Live entries that a flush discards: the head only if it was not emitted.
   assign lost_cnt = {1'b0, main_valid_q & ~out_ready} + {1'b0, skid_valid_q};
   assign cnt_sum  = {1'b0, flush_cnt_q} + (CNT_W + 1)'(lost_cnt);

   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      flush_cnt_d  = flush_cnt_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
         main_data_d  = FLUSH_VAL;
         flush_cnt_d  = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
      end else if (emit) begin
         if (skid_valid_q) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_data_d = in_data;
         end else begin
            main_valid_d = 1'b0;
            main_data_d  = FLUSH_VAL;
         end
      end else if (accept) begin
         // Unreachable with SKID=0: in_ready then requires empty or emitting.
         if (main_valid_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
         end else begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         main_valid_q <= 1'b0;
         main_data_q  <= RESET_VAL;
         skid_valid_q <= 1'b0;
         skid_data_q  <= RESET_VAL;
         flush_cnt_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;
   assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (skid, skid with 2-bit counter,
// single entry) share one stimulus and are compared against a queue model.
module tb_pipe_stage_reg;

   localparam logic [15:0] FV = 16'hF00D;

   logic clk = 1'b0;
   logic reset_n, in_valid, flush, out_ready;
   logic [15:0] in_data;

   logic [2:0]       ir, ov;
   logic [2:0][15:0] od;
   logic [2:0][1:0]  occ;
   logic [7:0]       fc0, fc2;
   logic [1:0]       fc_sat;
   logic [7:0]       fcv [3];

   assign fcv[0] = fc0;
   assign fcv[1] = {6'b0, fc_sat};
   assign fcv[2] = fc2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.WIDTH(16), .FLUSH_VAL(FV), .SKID(1'b1), .CNT_W(8)) u_skid (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[0]),
      .in_data(in_data), .flush(flush), .out_valid(ov[0]), .out_ready(out_ready),
      .out_data(od[0]), .occupancy(occ[0]), .flush_cnt(fc0));

   pipe_stage_reg #(.WIDTH(16), .FLUSH_VAL(FV), .SKID(1'b1), .CNT_W(2)) u_sat (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[1]),
      .in_data(in_data), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready),
      .out_data(od[1]), .occupancy(occ[1]), .flush_cnt(fc_sat));

   pipe_stage_reg #(.WIDTH(16), .FLUSH_VAL(FV), .SKID(1'b0), .CNT_W(8)) u_nos (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[2]),
      .in_data(in_data), .flush(flush), .out_valid(ov[2]), .out_ready(out_ready),
      .out_data(od[2]), .occupancy(occ[2]), .flush_cnt(fc2));

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: FIFO of capacity 2 (skid) or 1, plus the value shown when empty.
   int          cap  [3] = '{2, 2, 1};
   int          cmax [3] = '{255, 3, 255};
   int          mn   [3];
   logic [15:0] mq   [3][2];
   int          mcnt [3];
   logic [15:0] mempty [3];
   bit          armed = 1'b0;

   function automatic bit mrdy(input int i);
      return (cap[i] == 2) ? (mn[i] < 2) : (mn[i] == 0 || out_ready);
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         bit acc, emt;
         acc = in_valid && mrdy(i);
         emt = (mn[i] > 0) && out_ready;
         if (!reset_n) begin
            mn[i] = 0; mcnt[i] = 0; mempty[i] = 16'h0000;
            armed = 1'b1;
         end else if (flush) begin
            mcnt[i] = mcnt[i] + mn[i] - int'(emt);
            if (mcnt[i] > cmax[i]) mcnt[i] = cmax[i];
            mn[i] = 0; mempty[i] = FV;
         end else begin
            if (emt) begin
               mq[i][0] = mq[i][1];
               mn[i]--;
               if (mn[i] == 0 && !acc) mempty[i] = FV;
            end
            if (acc) begin
               mq[i][mn[i]] = in_data;
               mn[i]++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("m%0d.out_valid", i), int'(ov[i]), int'(mn[i] > 0));
            chk($sformatf("m%0d.out_data", i), int'(od[i]),
                int'((mn[i] > 0) ? mq[i][0] : mempty[i]));
            chk($sformatf("m%0d.occupancy", i), int'(occ[i]), mn[i]);
            chk($sformatf("m%0d.flush_cnt", i), int'(fcv[i]), mcnt[i]);
            chk($sformatf("m%0d.in_ready", i), int'(ir[i]), int'(mrdy(i)));
         end
      end
   end

   task automatic step(input logic v, input logic [15:0] d, input logic f, input logic r);
      in_valid = v; in_data = d; flush = f; out_ready = r;
      @(posedge clk);
      #1;
   endtask

   int sat_exp [5] = '{1, 2, 3, 3, 3};

   initial begin
      reset_n = 1'b0;
      step(1'b1, 16'hABCD, 1'b0, 1'b0);
      step(1'b1, 16'hABCD, 1'b0, 1'b0);
      chk("rst.out_valid", int'(ov[0]), 0);
      chk("rst.out_data", int'(od[0]), 16'h0000);
      chk("rst.occupancy", int'(occ[0]), 0);
      chk("rst.flush_cnt", int'(fc0), 0);
      reset_n = 1'b1;
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      chk("rst.in_ready", int'(ir[0]), 1);

      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 16'(k), 1'b0, 1'b1);
         chk($sformatf("stream%0d.data", k), int'(od[0]), k);
         chk($sformatf("stream%0d.valid", k), int'(ov[0]), 1);
         chk($sformatf("stream%0d.occ", k), int'(occ[0]), 1);
         chk($sformatf("stream%0d.in_ready", k), int'(ir[0]), 1);
         chk($sformatf("stream%0d.nos_data", k), int'(od[2]), k);
      end
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("drain.valid", int'(ov[0]), 0);
      chk("drain.bubble", int'(od[0]), FV);

      step(1'b1, 16'h0011, 1'b0, 1'b0);
      chk("bp.occ1", int'(occ[0]), 1);
      step(1'b1, 16'h0022, 1'b0, 1'b0);
      chk("bp.occ2", int'(occ[0]), 2);
      chk("bp.in_ready", int'(ir[0]), 0);
      chk("bp.head", int'(od[0]), 16'h0011);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("bp.second", int'(od[0]), 16'h0022);
      chk("bp.in_ready_back", int'(ir[0]), 1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("bp.empty", int'(ov[0]), 0);

      step(1'b1, 16'h0044, 1'b0, 1'b0);
      step(1'b1, 16'h0055, 1'b0, 1'b0);
      chk("fl.occ_full", int'(occ[0]), 2);
      step(1'b1, 16'h0033, 1'b1, 1'b0);
      chk("fl.valid", int'(ov[0]), 0);
      chk("fl.data", int'(od[0]), FV);
      chk("fl.occ", int'(occ[0]), 0);
      chk("fl.cnt", int'(fc0), 2);
      chk("fl.cnt_nos", int'(fc2), 1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("fl.no33", int'(ov[0]), 0);
      chk("fl.in_ready", int'(ir[0]), 1);

      step(1'b1, 16'h0066, 1'b0, 1'b0);
      chk("fe.occ", int'(occ[0]), 1);
      step(1'b0, 16'h0000, 1'b1, 1'b1);
      chk("fe.cnt", int'(fc0), 2);
      chk("fe.valid", int'(ov[0]), 0);

      reset_n = 1'b0;
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      reset_n = 1'b1;
      for (int j = 0; j < 5; j++) begin
         step(1'b1, 16'h0077, 1'b0, 1'b0);
         step(1'b0, 16'h0000, 1'b1, 1'b0);
         chk($sformatf("sat%0d", j), int'(fc_sat), sat_exp[j]);
         chk($sformatf("cnt8_%0d", j), int'(fc0), j + 1);
      end

      step(1'b1, 16'h0088, 1'b0, 1'b0);
      chk("nos.valid", int'(ov[2]), 1);
      chk("nos.data", int'(od[2]), 16'h0088);
      chk("nos.ready_lo", int'(ir[2]), 0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("nos.ready_hi", int'(ir[2]), 1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("nos.empty", int'(ov[2]), 0);
      chk("nos.bubble", int'(od[2]), FV);

      step(1'b0, 16'h0000, 1'b0, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
